// File: rtl/regfile_write_arbiter_if.sv
// Bus bundle between the two write requesters, the bulk-clear control and the
// register file write port of regfile_write_arbiter.
interface regfile_write_arbiter_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic              Vld0;
  logic [ADDR_W-1:0] Addr0;
  logic [DATA_W-1:0] Data0;
  logic              Rdy0;
  logic              Vld1;
  logic [ADDR_W-1:0] Addr1;
  logic [DATA_W-1:0] Data1;
  logic              Rdy1;
  logic              Clr_Req;
  logic              Clr_Busy;
  logic              Clr_Done;
  logic [ADDR_W-1:0] W_Addr;
  logic [DATA_W-1:0] W_Data;
  logic              Write_Reg;

  modport master (
    output Vld0, Addr0, Data0, Vld1, Addr1, Data1, Clr_Req,
    input  Rdy0, Rdy1, Clr_Busy, Clr_Done, W_Addr, W_Data, Write_Reg
  );

  modport slave (
    input  Vld0, Addr0, Data0, Vld1, Addr1, Data1, Clr_Req,
    output Rdy0, Rdy1, Clr_Busy, Clr_Done, W_Addr, W_Data, Write_Reg
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter for the single register file write port, with a
// sequenced bulk clear of registers 1..31 that leaves register 0 untouched.
module regfile_write_arbiter #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic                    Clk,
  input  logic                    Reset,
  regfile_write_arbiter_if.slave  bus
);

  typedef enum logic {IDLE, CLEAR} state_t;

  localparam logic [ADDR_W-1:0] FIRST_ADDR = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] LAST_ADDR  = {ADDR_W{1'b1}};

  state_t            state, next_state;
  logic              last_grant;
  logic [ADDR_W-1:0] clr_cnt;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_data;
  logic              write_reg;
  logic              clr_done;
  logic              rdy0, rdy1;

  // last_grant==1 means requester 1 was served last, so requester 0 wins a tie.
  always_comb begin
    next_state = state;
    rdy0       = 1'b0;
    rdy1       = 1'b0;
    case (state)
      IDLE: begin
        if (bus.Clr_Req) begin
          next_state = CLEAR;
        end else begin
          rdy0 = bus.Vld0 & (~bus.Vld1 | last_grant);
          rdy1 = bus.Vld1 & (~bus.Vld0 | ~last_grant);
        end
      end
      CLEAR: begin
        if (clr_cnt == LAST_ADDR) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      clr_cnt    <= FIRST_ADDR;
      w_addr     <= '0;
      w_data     <= '0;
      write_reg  <= 1'b0;
      clr_done   <= 1'b0;
    end else begin
      state    <= next_state;
      clr_done <= 1'b0;
      if (state == CLEAR) begin
        w_addr    <= clr_cnt;
        w_data    <= '0;
        write_reg <= 1'b1;
        if (clr_cnt == LAST_ADDR) begin
          clr_cnt  <= FIRST_ADDR;
          clr_done <= 1'b1;
        end else begin
          clr_cnt <= clr_cnt + ADDR_W'(1);
        end
      // A grant to address 0 is acknowledged but never reaches the write enable.
      end else if (rdy0) begin
        last_grant <= 1'b0;
        write_reg  <= (bus.Addr0 != '0);
        if (bus.Addr0 != '0) begin
          w_addr <= bus.Addr0;
          w_data <= bus.Data0;
        end
      end else if (rdy1) begin
        last_grant <= 1'b1;
        write_reg  <= (bus.Addr1 != '0);
        if (bus.Addr1 != '0) begin
          w_addr <= bus.Addr1;
          w_data <= bus.Data1;
        end
      end else begin
        write_reg <= 1'b0;
      end
    end
  end

  assign bus.Rdy0      = rdy0;
  assign bus.Rdy1      = rdy1;
  assign bus.Clr_Busy  = (state == CLEAR);
  assign bus.Clr_Done  = clr_done;
  assign bus.W_Addr    = w_addr;
  assign bus.W_Data    = w_data;
  assign bus.Write_Reg = write_reg;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter: directed scenarios plus a
// randomized run against a cycle-level reference model of the arbiter rules.
module tb_regfile_write_arbiter;

  logic Clk;
  logic Reset;
  int   checks = 0;
  int   errors = 0;
  int   wr0_seen = 0;
  logic [31:0] rf [32];

  regfile_write_arbiter_if #(.ADDR_W(5), .DATA_W(32)) bus ();

  regfile_write_arbiter #(.ADDR_W(5), .DATA_W(32)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus.slave)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Register file stand-in; any write aimed at register 0 is counted as an error source.
  always @(posedge Clk) begin
    if (bus.Write_Reg) begin
      rf[bus.W_Addr] <= bus.W_Data;
      if (bus.W_Addr == 5'd0) wr0_seen <= wr0_seen + 1;
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                               input logic v1, input logic [4:0] a1, input logic [31:0] d1,
                               input logic clr);
    bus.Vld0 = v0; bus.Addr0 = a0; bus.Data0 = d0;
    bus.Vld1 = v1; bus.Addr1 = a1; bus.Data1 = d1;
    bus.Clr_Req = clr;
  endtask

  task automatic do_reset();
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
    Reset = 1'b1;
    tick();
    tick();
    Reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++; if (bus.Write_Reg !== 1'b0) begin errors++; $display("[TB] FAIL reset_write_reg got %b expected 0", bus.Write_Reg); end
    checks++; if (bus.W_Addr !== 5'd0) begin errors++; $display("[TB] FAIL reset_w_addr got %0d expected 0", bus.W_Addr); end
    checks++; if (bus.W_Data !== 32'd0) begin errors++; $display("[TB] FAIL reset_w_data got %h expected 0", bus.W_Data); end
    checks++; if (bus.Clr_Busy !== 1'b0 || bus.Clr_Done !== 1'b0) begin errors++; $display("[TB] FAIL reset_clr got busy=%b done=%b expected 0/0", bus.Clr_Busy, bus.Clr_Done); end
    checks++; if (bus.Rdy0 !== 1'b0 || bus.Rdy1 !== 1'b0) begin errors++; $display("[TB] FAIL reset_rdy got %b%b expected 00", bus.Rdy0, bus.Rdy1); end
  endtask

  task automatic test_single();
    do_reset();
    applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 1'b0);
    #1;
    checks++; if (bus.Rdy0 !== 1'b1 || bus.Rdy1 !== 1'b0) begin errors++; $display("[TB] FAIL single_rdy got %b%b expected 10", bus.Rdy0, bus.Rdy1); end
    tick();
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
    checks++; if (bus.Write_Reg !== 1'b1 || bus.W_Addr !== 5'd5 || bus.W_Data !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL single_issue got we=%b a=%0d d=%h expected 1/5/deadbeef", bus.Write_Reg, bus.W_Addr, bus.W_Data); end
    tick();
    checks++; if (bus.Write_Reg !== 1'b0) begin errors++; $display("[TB] FAIL single_idle got %b expected 0", bus.Write_Reg); end
  endtask

  task automatic test_round_robin();
    logic [4:0] exp_a;
    do_reset();
    applyStimulus(1'b1, 5'd3, 32'h33, 1'b1, 5'd7, 32'h77, 1'b0);
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (bus.Rdy0 !== (i % 2 == 0) || bus.Rdy1 !== (i % 2 == 1)) begin errors++; $display("[TB] FAIL rr_grant[%0d] got %b%b expected grant to %0d", i, bus.Rdy0, bus.Rdy1, i % 2); end
      tick();
      exp_a = (i % 2 == 0) ? 5'd3 : 5'd7;
      checks++; if (bus.Write_Reg !== 1'b1 || bus.W_Addr !== exp_a) begin errors++; $display("[TB] FAIL rr_issue[%0d] got we=%b a=%0d expected 1/%0d", i, bus.Write_Reg, bus.W_Addr, exp_a); end
    end
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
    tick();
  endtask

  task automatic test_addr0();
    do_reset();
    applyStimulus(1'b1, 5'd3, 32'h33, 1'b1, 5'd7, 32'h77, 1'b0);
    tick();
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h1234, 1'b0);
    #1;
    checks++; if (bus.Rdy1 !== 1'b1) begin errors++; $display("[TB] FAIL addr0_rdy1 got %b expected 1", bus.Rdy1); end
    tick();
    applyStimulus(1'b1, 5'd3, 32'h33, 1'b1, 5'd7, 32'h77, 1'b0);
    checks++; if (bus.Write_Reg !== 1'b0) begin errors++; $display("[TB] FAIL addr0_drop got we=%b expected 0", bus.Write_Reg); end
    #1;
    checks++; if (bus.Rdy0 !== 1'b1 || bus.Rdy1 !== 1'b0) begin errors++; $display("[TB] FAIL addr0_pointer got %b%b expected 10", bus.Rdy0, bus.Rdy1); end
    tick();
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
    checks++; if (bus.Write_Reg !== 1'b1 || bus.W_Addr !== 5'd3) begin errors++; $display("[TB] FAIL addr0_next got we=%b a=%0d expected 1/3", bus.Write_Reg, bus.W_Addr); end
    tick();
  endtask

  task automatic test_bulk_clear();
    int bad_rdy = 0;
    int bad_wr  = 0;
    do_reset();
    applyStimulus(1'b1, 5'd4, 32'h44, 1'b0, 5'd0, 32'd0, 1'b1);
    #1;
    if (bus.Rdy0 !== 1'b0) bad_rdy++;
    tick();
    bus.Clr_Req = 1'b0;
    for (int k = 1; k <= 31; k++) begin
      #1;
      if (bus.Rdy0 !== 1'b0 || bus.Clr_Busy !== 1'b1 || bus.Clr_Done !== 1'b0) bad_rdy++;
      tick();
      if (bus.Write_Reg !== 1'b1 || bus.W_Addr !== 5'(k) || bus.W_Data !== 32'd0) begin
        bad_wr++;
        $display("[TB] FAIL clear_walk[%0d] got we=%b a=%0d d=%h expected 1/%0d/0", k, bus.Write_Reg, bus.W_Addr, bus.W_Data, k);
      end
    end
    checks++; if (bad_rdy != 0) begin errors++; $display("[TB] FAIL clear_hold got %0d bad cycles expected 0", bad_rdy); end
    checks++; if (bad_wr != 0) begin errors++; $display("[TB] FAIL clear_writes got %0d bad writes expected 0", bad_wr); end
    checks++; if (bus.Clr_Done !== 1'b1 || bus.Clr_Busy !== 1'b0) begin errors++; $display("[TB] FAIL clear_done got done=%b busy=%b expected 1/0", bus.Clr_Done, bus.Clr_Busy); end
    #1;
    checks++; if (bus.Rdy0 !== 1'b1) begin errors++; $display("[TB] FAIL clear_resume_rdy0 got %b expected 1", bus.Rdy0); end
    tick();
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
    checks++; if (bus.Clr_Done !== 1'b0 || bus.Write_Reg !== 1'b1 || bus.W_Addr !== 5'd4) begin errors++; $display("[TB] FAIL clear_after got done=%b we=%b a=%0d expected 0/1/4", bus.Clr_Done, bus.Write_Reg, bus.W_Addr); end
    tick();
  endtask

  task automatic test_reset_mid_clear();
    bit found = 0;
    int dones = 0;
    do_reset();
    bus.Clr_Req = 1'b1;
    tick();
    bus.Clr_Req = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      if (bus.Write_Reg === 1'b1 && bus.W_Addr === 5'd10) found = 1;
    end
    checks++; if (!found) begin errors++; $display("[TB] FAIL midclr_reach10 got timeout expected W_Addr=10"); end
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    checks++; if (bus.Write_Reg !== 1'b0 || bus.Clr_Busy !== 1'b0 || bus.Clr_Done !== 1'b0) begin errors++; $display("[TB] FAIL midclr_reset got we=%b busy=%b done=%b expected 0/0/0", bus.Write_Reg, bus.Clr_Busy, bus.Clr_Done); end
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.Clr_Done !== 1'b0) dones++;
    end
    checks++; if (dones != 0) begin errors++; $display("[TB] FAIL midclr_no_done got %0d pulses expected 0", dones); end
    bus.Clr_Req = 1'b1;
    tick();
    bus.Clr_Req = 1'b0;
    tick();
    checks++; if (bus.Write_Reg !== 1'b1 || bus.W_Addr !== 5'd1) begin errors++; $display("[TB] FAIL midclr_restart got we=%b a=%0d expected 1/1", bus.Write_Reg, bus.W_Addr); end
    for (int i = 0; i < 32; i++) tick();
  endtask

  task automatic test_regfile();
    bit done_seen = 0;
    do_reset();
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'hA5A5A5A5, 1'b0);
    #1;
    checks++; if (bus.Rdy1 !== 1'b1) begin errors++; $display("[TB] FAIL rf_rdy1 got %b expected 1", bus.Rdy1); end
    tick();
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
    tick();
    checks++; if (rf[9] !== 32'hA5A5A5A5) begin errors++; $display("[TB] FAIL rf_write9 got %h expected a5a5a5a5", rf[9]); end
    bus.Clr_Req = 1'b1;
    tick();
    bus.Clr_Req = 1'b0;
    for (int i = 0; i < 50 && !done_seen; i++) begin
      tick();
      if (bus.Clr_Done === 1'b1) done_seen = 1;
    end
    checks++; if (!done_seen) begin errors++; $display("[TB] FAIL rf_clr_done got timeout expected pulse"); end
    tick();
    checks++; if (rf[9] !== 32'd0) begin errors++; $display("[TB] FAIL rf_cleared9 got %h expected 0", rf[9]); end
    checks++; if (rf[31] !== 32'd0) begin errors++; $display("[TB] FAIL rf_cleared31 got %h expected 0", rf[31]); end
  endtask

  // Reference model: clr_left counts clear writes still owed; address = 32 - clr_left.
  task automatic test_random();
    int          last_g = 1;
    int          clr_left = 0;
    bit          p0 = 0, p1 = 0, clr, g0, g1, busy, exp_wr, exp_done;
    logic [4:0]  a0 = 0, a1 = 0, exp_a = 0;
    logic [31:0] d0 = 0, d1 = 0, exp_d = 0;
    int          bad = 0;
    do_reset();
    for (int c = 0; c < 800; c++) begin
      if (!p0 && $urandom_range(1, 0) == 1) begin p0 = 1; a0 = 5'($urandom_range(31, 0)); d0 = $urandom; end
      if (!p1 && $urandom_range(1, 0) == 1) begin p1 = 1; a1 = 5'($urandom_range(31, 0)); d1 = $urandom; end
      clr = ($urandom_range(29, 0) == 0);
      applyStimulus(p0, a0, d0, p1, a1, d1, clr);
      busy = (clr_left > 0);
      g0 = 0; g1 = 0; exp_wr = 0; exp_done = 0;
      if (busy) begin
        exp_wr = 1; exp_a = 5'(32 - clr_left); exp_d = 0;
        clr_left--;
        exp_done = (clr_left == 0);
      end else if (clr) begin
        clr_left = 31;
      end else if (p0 && p1) begin
        if (last_g == 1) g0 = 1; else g1 = 1;
      end else begin
        g0 = p0; g1 = p1;
      end
      if (g0) begin last_g = 0; exp_wr = (a0 != 0); exp_a = a0; exp_d = d0; p0 = 0; end
      if (g1) begin last_g = 1; exp_wr = (a1 != 0); exp_a = a1; exp_d = d1; p1 = 0; end
      #1;
      checks++; if (bus.Rdy0 !== g0 || bus.Rdy1 !== g1 || bus.Clr_Busy !== busy) begin
        errors++; bad++;
        if (bad < 10) $display("[TB] FAIL rand_rdy cycle %0d got rdy=%b%b busy=%b expected %b%b/%b", c, bus.Rdy0, bus.Rdy1, bus.Clr_Busy, g0, g1, busy);
      end
      tick();
      checks++; if (bus.Write_Reg !== exp_wr || bus.Clr_Done !== exp_done ||
                    (exp_wr && (bus.W_Addr !== exp_a || bus.W_Data !== exp_d))) begin
        errors++; bad++;
        if (bad < 10) $display("[TB] FAIL rand_issue cycle %0d got we=%b a=%0d d=%h done=%b expected %b/%0d/%h/%b", c, bus.Write_Reg, bus.W_Addr, bus.W_Data, bus.Clr_Done, exp_wr, exp_a, exp_d, exp_done);
      end
    end
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
    for (int i = 0; i < 34; i++) tick();
  endtask

  initial begin
    Reset = 1'b1;
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
    test_reset();
    test_single();
    test_round_robin();
    test_addr0();
    test_bulk_clear();
    test_reset_mid_clear();
    test_regfile();
    test_random();
    checks++; if (wr0_seen != 0) begin errors++; $display("[TB] FAIL reg0_untouched got %0d writes expected 0", wr0_seen); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the single write port of the 32x32 register file between two requesters: requester 0 is pipeline writeback, requester 1 is the debug/loader port.
- Also provides a sequenced bulk-clear of registers 1..31 without asserting the register file's own Reset.
- Sits between the requesters and the register file's W_Addr / W_Data / Write_Reg inputs.
- Registered outputs; one write is issued per cycle at most.

Parameters:
- ADDR_W, 5, register address width (32 registers).
- DATA_W, 32, write data width.

Ports:
- Clk  input  1  clock; all state updates on the rising edge.
- Reset  input  1  synchronous, active-high reset.
- Vld0  input  1  requester 0 write request valid.
- Addr0  input  ADDR_W  requester 0 target register.
- Data0  input  DATA_W  requester 0 write data.
- Rdy0  output  1  requester 0 accepted this cycle (combinational).
- Vld1  input  1  requester 1 write request valid.
- Addr1  input  ADDR_W  requester 1 target register.
- Data1  input  DATA_W  requester 1 write data.
- Rdy1  output  1  requester 1 accepted this cycle (combinational).
- Clr_Req  input  1  start a bulk clear (level, sampled in IDLE).
- Clr_Busy  output  1  high while in CLEAR.
- Clr_Done  output  1  one-cycle pulse after the last clear write.
- W_Addr  output  ADDR_W  to register file.
- W_Data  output  DATA_W  to register file.
- Write_Reg  output  1  to register file, write enable.

Behaviour:
- Clock and reset: one clock, Clk. Reset is synchronous and active-high.
- Reset values: state=IDLE, W_Addr=0, W_Data=0, Write_Reg=0, Clr_Busy=0, Clr_Done=0, last-grant pointer=1 (so requester 0 wins the first conflict), clear counter=1.
- States:
  - IDLE: arbitration. On a cycle with Clr_Req=1, go to CLEAR. Clr_Req has priority over both Vld inputs: Rdy0=Rdy1=0 in that cycle, and no write is issued.
  - CLEAR: counter walks 1..31. Each cycle issues W_Addr=counter, W_Data=0, Write_Reg=1, then counter increments. When counter==31 is issued, go to IDLE next cycle, pulse Clr_Done for one cycle, and reset counter to 1. Duration is exactly 31 cycles of Write_Reg=1.
- Arbitration (IDLE only):
  - Rdy0 = Vld0 & (!Vld1 | last==1).
  - Rdy1 = Vld1 & (!Vld0 | last==0).
  - At most one Rdy is high per cycle.
  - The pointer updates to the granted requester only when a grant occurs. Sole requesters are always granted.
  - In CLEAR, Rdy0=Rdy1=0. Requesters hold Vld, Addr and Data until Rdy is seen.
- Issue latency: a request accepted in cycle N appears on W_Addr/W_Data with Write_Reg=1 in cycle N+1. Write_Reg=0 in any cycle following no grant.
- Address 0:
  - An accepted request with Addr=0 is still acknowledged (Rdy=1) and still consumes the grant and updates the pointer.
  - Its issue cycle has Write_Reg=0, so the write is silently dropped.
- Clr_Req held high continuously: a new clear starts in the cycle right after Clr_Done, because IDLE samples it again. Requesters starve by design.
- Reset asserted mid-CLEAR: the clear is abandoned immediately, all outputs take their reset values next edge, and no Clr_Done is produced.
- W_Addr/W_Data hold their last value when Write_Reg=0. The verifier checks them only when Write_Reg=1.

Test Plan:
- Reset then single request: Vld0=1, Addr0=5, Data0=0xDEADBEEF for one cycle -> Rdy0=1 that cycle; next cycle W_Addr=5, W_Data=0xDEADBEEF, Write_Reg=1; the cycle after, Write_Reg=0.
- Conflict round-robin: Vld0 and Vld1 held high with Addr0=3, Addr1=7 for 4 cycles after reset -> grants go 0,1,0,1; issued W_Addr sequence is 3,7,3,7.
- Address 0 drop: Vld1=1, Addr1=0, Data1=0x1234 -> Rdy1=1; next cycle Write_Reg=0; pointer now favours requester 0 on the next conflict.
- Bulk clear: pulse Clr_Req for one cycle in IDLE while Vld0=1 -> Rdy0=0 for all 32 cycles. Write_Reg=1 for 31 consecutive cycles with W_Addr 1..31 and W_Data=0. Clr_Done pulses once, Clr_Busy falls. Rdy0=1 on the first IDLE cycle after.
- Reset mid-clear: assert Reset when W_Addr=10 during CLEAR -> next edge Write_Reg=0, Clr_Busy=0, and Clr_Done is never asserted. A subsequent Clr_Req restarts the walk at W_Addr=1.
- Paired with the register file: write 0xA5A5A5A5 to register 9 via requester 1, then run a bulk clear -> register file read of address 9 returns 0 after Clr_Done, and register 0 reads 0 throughout.
